// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Receive-side byte buffer between a UART receiver and the host logic.
//   Each rx_valid pulse pushes one byte into a first-word-fall-through FIFO.
//   The head byte is presented on a valid/ready read port. If a byte arrives
//   while the buffer is full and nothing is being popped, the byte is dropped
//   and the sticky overflow flag is set.
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   synchronous reset, active-high
//   rx_data      in   received byte, sampled when rx_valid=1
//   rx_valid     in   push request, one cycle per byte
//   rd_data      out  head-of-FIFO byte, forced to 0 while rd_valid=0
//   rd_valid     out  FIFO not empty
//   rd_ready     in   consumer accepts rd_data (pop when rd_valid & rd_ready)
//   count        out  current occupancy, 0..DEPTH
//   full         out  count == DEPTH
//   almost_full  out  count >= AF_LEVEL
//   overflow     out  sticky, a byte was dropped
//   ovf_clr      in   clears overflow (a drop in the same cycle wins)
module uart_rx_fifo #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = 4,
    parameter int AF_LEVEL = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              almost_full,
    output logic              overflow,
    input  logic              ovf_clr
);

    localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] AF_C    = AF_LEVEL[ADDR_W:0];

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              push;
    logic              pop;
    logic              drop;

    assign rd_valid    = (count != '0);
    assign full        = (count == DEPTH_C);
    assign almost_full = (count >= AF_C);

    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign pop  = rd_valid & rd_ready;
    assign push = rx_valid & (~full | pop);
    assign drop = rx_valid & full & ~pop;

    assign rd_data = rd_valid ? mem[rd_ptr] : '0;

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (ADDR_W+1)'(1);
                2'b01:   count <= count - (ADDR_W+1)'(1);
                default: count <= count;
            endcase
            // Set has priority over clear.
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule
